display_p2s_scheduler: RTL and testbench

DISPLAY_P2S_SCHEDULER -- requirements
Module: display_p2s_scheduler

---
 rtl/display_p2s_scheduler_pkg.sv | 33 +++
 rtl/display_p2s_scheduler_serial_shift_engine.sv | 61 ++++++
 rtl/display_p2s_scheduler.sv | 157 +++++++++++++++
 tb/tb_display_p2s_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_p2s_scheduler_pkg.sv
// Shared types for the LED / seven-segment serial scheduler: FSM encoding,
// channel IDs, channel widths and the round-robin pick.
package display_p2s_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic CH_LED = 1'b0;
  localparam logic CH_SEG = 1'b1;

  localparam int unsigned LED_W    = 16;
  localparam int unsigned SEG_W    = 64;
  localparam int unsigned SHREG_W  = SEG_W;
  localparam int unsigned BITCNT_W = $clog2(SHREG_W);

  typedef logic [BITCNT_W:0] width_t;

  function automatic width_t ch_width(input logic ch);
    return (ch == CH_SEG) ? width_t'(SEG_W) : width_t'(LED_W);
  endfunction

  // With both channels pending, serve the one that did not go last.
  function automatic logic rr_pick(input logic [1:0] pend, input logic last);
    if (pend[CH_LED] && pend[CH_SEG]) return ~last;
    return pend[CH_SEG];
  endfunction

endpackage

// File: rtl/display_p2s_scheduler_serial_shift_engine.sv
// Bit timing and shift register: MSB-first, ser_clk low then high for CLK_DIV
// cycles per phase, shift on the falling edge. Frame data arrives left-aligned.
module serial_shift_engine
  import display_p2s_scheduler_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  width_t             width,
  input  logic [SHREG_W-1:0] data,
  output logic               ser_clk,
  output logic               ser_dat,
  output logic               last_bit
);

  localparam int unsigned   DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);

  logic [SHREG_W-1:0]  shreg_q;
  logic [BITCNT_W-1:0] bit_cnt_q;
  logic [DW-1:0]       div_cnt_q;
  logic                sclk_q;
  logic                active_q;
  logic                phase_end;

  assign phase_end = active_q && (div_cnt_q == DIV_M1);
  assign last_bit  = phase_end && sclk_q && (bit_cnt_q == '0);

  // Zeros shift in behind the data, so ser_dat falls back to 0 once the frame is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      active_q  <= 1'b0;
    end else if (start) begin
      shreg_q   <= data;
      bit_cnt_q <= BITCNT_W'(width - width_t'(1));
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      active_q  <= 1'b1;
    end else if (phase_end) begin
      div_cnt_q <= '0;
      sclk_q    <= ~sclk_q;
      if (sclk_q) begin
        shreg_q   <= {shreg_q[SHREG_W-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - BITCNT_W'(1);
        if (bit_cnt_q == '0) active_q <= 1'b0;
      end
    end else if (active_q) begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  assign ser_clk = sclk_q;
  assign ser_dat = shreg_q[SHREG_W-1];

endmodule

// File: rtl/display_p2s_scheduler.sv
// Time-shares one serial path between a 16-bit LED and a 64-bit SEG image.
// Update pulse to LOAD in 1 cycle; no backpressure, repeated updates coalesce into pending flags.
module display_p2s_scheduler
  import display_p2s_scheduler_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_PERIOD = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_data,
  input  logic        led_upd,
  input  logic [63:0] seg_data,
  input  logic        seg_upd,
  output logic        ser_clk,
  output logic        ser_dat,
  output logic        led_pen,
  output logic        seg_pen,
  output logic        busy,
  output logic        cur_ch,
  output logic        done
);

  localparam int unsigned   DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);

  state_t             state_q;
  logic               cur_ch_q;
  logic               last_q;
  logic               busy_q;
  logic               done_q;
  logic               led_pen_q;
  logic               seg_pen_q;
  logic [DW-1:0]      wait_q;
  logic [1:0]         pend_q;
  logic [1:0]         pend_d;
  logic [1:0]         pend_set;
  logic [1:0]         pend_eff;
  logic               sel;
  logic               ref_tick;
  logic               last_bit;
  logic [SHREG_W-1:0] eng_data;

  generate
    if (REFRESH_PERIOD == 0) begin : g_no_refresh
      assign ref_tick = 1'b0;
    end else begin : g_refresh
      localparam int unsigned   RW     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
      localparam logic [RW-1:0] REF_M1 = RW'(REFRESH_PERIOD - 1);
      logic [RW-1:0] ref_cnt_q;
      logic [RW-1:0] ref_cnt_d;

      assign ref_tick  = (ref_cnt_q == REF_M1);
      assign ref_cnt_d = ref_tick ? '0 : ref_cnt_q + RW'(1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ref_cnt_q <= '0;
        else     ref_cnt_q <= ref_cnt_d;
      end
    end
  endgenerate

  assign pend_set = {seg_upd | ref_tick, led_upd | ref_tick};
  assign pend_eff = pend_q | pend_set;
  assign sel      = rr_pick(pend_eff, last_q);

  // The clear lands at the end of the LOAD cycle; a same-cycle set overrides it.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_LOAD) pend_d[cur_ch_q] = 1'b0;
    pend_d = pend_d | pend_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 2'b11;
    else     pend_q <= pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_ch_q  <= CH_LED;
      last_q    <= CH_SEG;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_pen_q <= 1'b1;
      seg_pen_q <= 1'b1;
      wait_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|pend_eff) begin
            state_q   <= ST_LOAD;
            cur_ch_q  <= sel;
            last_q    <= sel;
            busy_q    <= 1'b1;
            led_pen_q <= (sel != CH_LED);
            seg_pen_q <= (sel != CH_SEG);
          end
        end
        ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (last_bit) begin
            state_q   <= ST_LATCH;
            led_pen_q <= 1'b1;
            seg_pen_q <= 1'b1;
            wait_q    <= '0;
            done_q    <= (DIV_M1 == '0);
          end
        end
        ST_LATCH: begin
          if (wait_q == DIV_M1) begin
            state_q <= ST_GAP;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + DW'(1);
            done_q <= ((wait_q + DW'(1)) == DIV_M1);
          end
        end
        ST_GAP: begin
          if (wait_q == DIV_M1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eng_data = (cur_ch_q == CH_SEG) ? seg_data
                                         : {led_data, {(SHREG_W - LED_W){1'b0}}};

  serial_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (state_q == ST_LOAD),
    .width   (ch_width(cur_ch_q)),
    .data    (eng_data),
    .ser_clk (ser_clk),
    .ser_dat (ser_dat),
    .last_bit(last_bit)
  );

  assign led_pen = led_pen_q;
  assign seg_pen = seg_pen_q;
  assign busy    = busy_q;
  assign cur_ch  = cur_ch_q;
  assign done    = done_q;

endmodule

// File: tb/tb_display_p2s_scheduler.sv
// Directed bench: frame order, timing, bit content, update coalescing, refresh and async reset.
module tb_display_p2s_scheduler;

  typedef struct {
    logic        ch;
    int          start;
    int          len;
    int          led_low;
    int          seg_low;
    int          dones;
    int          done_at;
    logic [63:0] bits;
    int          nbits;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_r;
  logic [15:0] led_data;
  logic        led_upd;
  logic [63:0] seg_data;
  logic        seg_upd;
  logic        ser_clk, ser_dat, led_pen, seg_pen, busy, cur_ch, done;
  logic        ser_clk_r, ser_dat_r, led_pen_r, seg_pen_r, busy_r, cur_ch_r, done_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_total = 0;
  int t0, t1, dsave, nbusy;
  logic in_frame = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_busy_r = 1'b0;
  frame_t cur;
  frame_t f0, f1;
  frame_t frames[$];
  int rs_ch[$];
  int rs_cyc[$];
  int exp_off[6] = '{1, 71, 1000, 1070, 2000, 2070};

  always #5 clk = ~clk;

  display_p2s_scheduler #(.CLK_DIV(2), .REFRESH_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .led_data(led_data), .led_upd(led_upd),
    .seg_data(seg_data), .seg_upd(seg_upd), .ser_clk(ser_clk), .ser_dat(ser_dat),
    .led_pen(led_pen), .seg_pen(seg_pen), .busy(busy), .cur_ch(cur_ch), .done(done)
  );

  display_p2s_scheduler #(.CLK_DIV(2), .REFRESH_PERIOD(1000)) dut_r (
    .clk(clk), .rst(rst_r), .led_data(16'h5A5A), .led_upd(1'b0),
    .seg_data(64'h1122334455667788), .seg_upd(1'b0), .ser_clk(ser_clk_r), .ser_dat(ser_dat_r),
    .led_pen(led_pen_r), .seg_pen(seg_pen_r), .busy(busy_r), .cur_ch(cur_ch_r), .done(done_r)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_frame = 1'b0;
    end else if (busy) begin
      if (!in_frame) begin
        in_frame    = 1'b1;
        cur.ch      = cur_ch;
        cur.start   = cyc;
        cur.len     = 0;
        cur.led_low = 0;
        cur.seg_low = 0;
        cur.dones   = 0;
        cur.done_at = 0;
        cur.bits    = '0;
        cur.nbits   = 0;
      end
      cur.len = cur.len + 1;
      if (!led_pen) cur.led_low = cur.led_low + 1;
      if (!seg_pen) cur.seg_low = cur.seg_low + 1;
      if (ser_clk && !prev_sclk) begin
        cur.bits  = {cur.bits[62:0], ser_dat};
        cur.nbits = cur.nbits + 1;
      end
    end else if (in_frame) begin
      in_frame = 1'b0;
      frames.push_back(cur);
    end
    if (done) begin
      done_total  = done_total + 1;
      cur.dones   = cur.dones + 1;
      cur.done_at = cur.len;
    end
    prev_sclk = ser_clk;
    if (busy_r && !prev_busy_r) begin
      rs_ch.push_back(int'(cur_ch_r));
      rs_cyc.push_back(cyc);
    end
    prev_busy_r = busy_r;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("frame_timeout", 64'(frames.size() >= n), 64'd1);
  endtask

  task automatic get_frame(output frame_t fr);
    fr.ch = 1'b0; fr.start = -1; fr.len = 0; fr.led_low = 0; fr.seg_low = 0;
    fr.dones = 0; fr.done_at = 0; fr.bits = '0; fr.nbits = 0;
    if (frames.size() > 0) fr = frames.pop_front();
  endtask

  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_r = 1'b1;
    led_upd = 1'b0; seg_upd = 1'b0;
    led_data = 16'h1234; seg_data = 64'h0123456789ABCDEF;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_led_pen", led_pen, 1);
    chk("rst_seg_pen", seg_pen, 1);
    chk("rst_ser_clk", ser_clk, 0);
    chk("rst_ser_dat", ser_dat, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_ch", cur_ch, 0);

    // Post-reset: LED first, then SEG, then quiet.
    rst = 1'b0;
    t0 = cyc;
    wait_frames(2, 800);
    get_frame(f0);
    chk("a_led_ch", f0.ch, 0);
    chk("a_led_start", f0.start, t0 + 1);
    chk("a_led_len", f0.len, 69);
    chk("a_led_pen_low", f0.led_low, 65);
    chk("a_led_segpen", f0.seg_low, 0);
    chk("a_led_dones", f0.dones, 1);
    chk("a_led_done_at", f0.done_at, 67);
    chk("a_led_nbits", f0.nbits, 16);
    chk("a_led_bits", f0.bits, 64'h1234);
    get_frame(f1);
    chk("a_seg_ch", f1.ch, 1);
    chk("a_seg_start", f1.start, t0 + 71);
    chk("a_seg_len", f1.len, 261);
    chk("a_seg_pen_low", f1.seg_low, 257);
    chk("a_seg_ledpen", f1.led_low, 0);
    chk("a_seg_done_at", f1.done_at, 259);
    chk("a_seg_nbits", f1.nbits, 64);
    chk("a_seg_bits", f1.bits, 64'h0123456789ABCDEF);
    count_busy(30, nbusy);
    chk("a_idle_after", nbusy, 0);

    // Single LED update.
    led_data = 16'hA5C3;
    led_upd = 1'b1;
    step();
    led_upd = 1'b0;
    chk("b_load_busy", busy, 1);
    chk("b_load_ch", cur_ch, 0);
    chk("b_load_led_pen", led_pen, 0);
    chk("b_load_seg_pen", seg_pen, 1);
    chk("b_load_sclk", ser_clk, 0);
    wait_frames(1, 200);
    get_frame(f0);
    chk("b_len", f0.len, 69);
    chk("b_led_low", f0.led_low, 65);
    chk("b_seg_low", f0.seg_low, 0);
    chk("b_bits", f0.bits, 64'hA5C3);
    count_busy(20, nbusy);
    chk("b_no_resend", nbusy, 0);

    // Simultaneous updates after LED was last: SEG wins, LED follows.
    seg_data = 64'hF0E1D2C3B4A59687;
    led_upd = 1'b1; seg_upd = 1'b1;
    step();
    led_upd = 1'b0; seg_upd = 1'b0;
    chk("c_first_ch", cur_ch, 1);
    wait_frames(2, 800);
    get_frame(f0);
    get_frame(f1);
    chk("c_f0_ch", f0.ch, 1);
    chk("c_f0_len", f0.len, 261);
    chk("c_f0_bits", f0.bits, 64'hF0E1D2C3B4A59687);
    chk("c_f1_ch", f1.ch, 0);
    chk("c_f1_len", f1.len, 69);
    chk("c_f1_gap", f1.start - f0.start, 262);
    chk("c_f1_bits", f1.bits, 64'hA5C3);

    // LED update mid-shift: frame in flight keeps old image, resend carries new one.
    led_data = 16'h8E71;
    led_upd = 1'b1;
    step();
    led_upd = 1'b0;
    repeat (20) step();
    led_data = 16'h0001;
    led_upd = 1'b1;
    step();
    led_upd = 1'b0;
    wait_frames(2, 400);
    get_frame(f0);
    get_frame(f1);
    chk("d_f0_bits", f0.bits, 64'h8E71);
    chk("d_f0_len", f0.len, 69);
    chk("d_f1_ch", f1.ch, 0);
    chk("d_f1_bits", f1.bits, 64'h0001);
    count_busy(20, nbusy);
    chk("d_idle_after", nbusy, 0);

    // Reset during the high phase of SEG bit 30.
    seg_data = 64'hDEADBEEFCAFEF00D;
    seg_upd = 1'b1;
    step();
    seg_upd = 1'b0;
    chk("e_load_ch", cur_ch, 1);
    repeat (123) step();
    chk("e_bit30_sclk", ser_clk, 1);
    chk("e_bit30_dat", ser_dat, 1);
    chk("e_bit30_pen", seg_pen, 0);
    dsave = done_total;
    #2;
    rst = 1'b1;
    #1;
    chk("e_rst_seg_pen", seg_pen, 1);
    chk("e_rst_led_pen", led_pen, 1);
    chk("e_rst_sclk", ser_clk, 0);
    chk("e_rst_dat", ser_dat, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_done", done, 0);
    step();
    step();
    rst = 1'b0;
    chk("e_no_frame", frames.size(), 0);
    chk("e_no_done", done_total, dsave);
    wait_frames(2, 800);
    get_frame(f0);
    get_frame(f1);
    chk("e_f0_ch", f0.ch, 0);
    chk("e_f0_bits", f0.bits, 64'h0001);
    chk("e_f1_ch", f1.ch, 1);
    chk("e_f1_len", f1.len, 261);
    chk("e_f1_bits", f1.bits, 64'hDEADBEEFCAFEF00D);
    chk("e_done_count", done_total, dsave + 2);

    // Refresh instance: frame starts pinned to the 1000-cycle period.
    rst_r = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 2400) step();
    chk("f_nstarts", rs_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rs_cyc.size()) begin
        chk($sformatf("f_start%0d", i), rs_cyc[i] - t1, exp_off[i]);
        chk($sformatf("f_ch%0d", i), rs_ch[i], i % 2);
      end
    end
    chk("f_idle_sclk", ser_clk_r, 0);
    chk("f_idle_dat", ser_dat_r, 0);
    chk("f_idle_led_pen", led_pen_r, 1);
    chk("f_idle_seg_pen", seg_pen_r, 1);
    chk("f_idle_done", done_r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
